// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: single-address I2C target with no clock stretching.
// SCL and SDA are oversampled on the system clock. Written bytes are ACKed and
// presented on rx_data. Read bytes are fetched from tx_data with a tx_load
// handshake. Multi-byte transfers and repeated START are supported.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | bus idle or not addressed, waiting for START
// ST_ADDR     | shifting 7 address bits + R/W
// ST_ADDR_ACK | driving the address ACK, then branching to write or read
// ST_WRITE    | shifting a byte written by the master
// ST_DATA_ACK | driving the ACK for a written byte
// ST_READ     | driving bits 6..0 of the current read byte
// ST_MACK     | SDA released, sampling the master ACK/NACK
// ST_WAIT_STOP| not addressed or read ended; waiting for STOP or START
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1010101,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i2c_clock_in,
  input  logic       i2c_reset_in,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       stop_det,
  inout  wire        i2c_scl_inout,
  inout  wire        i2c_sda_inout
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WRITE,
    ST_DATA_ACK, ST_READ, ST_MACK, ST_WAIT_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [6:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   rw_q, rw_d;
  logic                   ack_drv_q, ack_drv_d;
  logic                   load_pend_q, load_pend_d;
  logic [6:0]             tx_shift_q, tx_shift_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_load_q, tx_load_d;
  logic                   stop_det_q, stop_det_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, fall_early;
  logic start_ev, stop_ev;

  // SCL is observed only; SDA is open-drain and never driven high.
  assign i2c_scl_inout = 1'bz;
  assign i2c_sda_inout = sda_oe_q ? 1'b0 : 1'bz;

  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign stop_det = stop_det_q;

  // Bus events derived from the synchronised lines and their history flops.
  always_comb begin
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_rise   = scl_s & ~scl_prev_q;
    scl_fall   = ~scl_s & scl_prev_q;
    // The next-to-last stage runs one cycle ahead, so this flags the fall a
    // cycle early and lets tx_load land exactly in the scl_fall cycle.
    fall_early = scl_s & ~scl_sync_q[SYNC_STAGES-2];
    start_ev   = scl_s & sda_prev_q & ~sda_s;
    stop_ev    = scl_s & ~sda_prev_q & sda_s;
  end

  // Next-state and next-output computation for the whole target.
  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl_inout};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda_inout};
    scl_prev_d  = scl_s;
    sda_prev_d  = sda_s;
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rw_d        = rw_q;
    ack_drv_d   = ack_drv_q;
    load_pend_d = load_pend_q;
    tx_shift_d  = tx_shift_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    stop_det_d  = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_ADDR: begin
        if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d      = sda_s;
            ack_drv_d = 1'b0;
            if (shift_q == SLAVE_ADDR) begin
              state_d = ST_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end
      end
      ST_ADDR_ACK: begin
        if (scl_fall) begin
          if (!ack_drv_q) begin
            sda_oe_d    = 1'b1;
            busy_d      = 1'b1;
            ack_drv_d   = 1'b1;
            load_pend_d = rw_q;
          end else if (!rw_q) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (scl_rise) begin
          shift_d   = {shift_q[5:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {shift_q, sda_s};
            rx_valid_d = 1'b1;
            ack_drv_d  = 1'b0;
            state_d    = ST_DATA_ACK;
          end
        end
      end
      ST_DATA_ACK: begin
        if (scl_fall) begin
          if (!ack_drv_q) begin
            sda_oe_d  = 1'b1;
            ack_drv_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        // bit_cnt counts bits already driven; it wraps to 0 after bit0.
        if (scl_fall) begin
          if (bit_cnt_q != 3'd0) begin
            sda_oe_d   = ~tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_MACK;
          end
        end
      end
      ST_MACK: begin
        if (scl_rise && !load_pend_q) begin
          if (!sda_s) begin
            load_pend_d = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_WAIT_STOP;
          end
        end
      end
      ST_WAIT_STOP: sda_oe_d = 1'b0;
      default: state_d = ST_IDLE;
    endcase

    // Shared byte fetch for the first read byte and every ACKed follow-on.
    if (load_pend_q) begin
      if (fall_early) begin
        tx_load_d = 1'b1;
      end
      if (scl_fall) begin
        tx_shift_d  = tx_data[6:0];
        sda_oe_d    = ~tx_data[7];
        bit_cnt_d   = 3'd1;
        load_pend_d = 1'b0;
        state_d     = ST_READ;
      end
    end

    if (start_ev) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      ack_drv_d   = 1'b0;
      load_pend_d = 1'b0;
      tx_load_d   = 1'b0;
    end

    // STOP takes priority over a coincident START.
    if (stop_ev) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      ack_drv_d   = 1'b0;
      load_pend_d = 1'b0;
      tx_load_d   = 1'b0;
      busy_d      = 1'b0;
      stop_det_d  = 1'b1;
    end
  end

  // State register; synchronisers reset to the idle-high bus level.
  always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
    if (i2c_reset_in) begin
      state_q     <= ST_IDLE;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      shift_q     <= 7'd0;
      bit_cnt_q   <= 3'd0;
      rw_q        <= 1'b0;
      ack_drv_q   <= 1'b0;
      load_pend_q <= 1'b0;
      tx_shift_q  <= 7'd0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rw_q        <= rw_d;
      ack_drv_q   <= ack_drv_d;
      load_pend_q <= load_pend_d;
      tx_shift_q  <= tx_shift_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      stop_det_q  <= stop_det_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged master on a pulled-up
// open-drain bus plus pulse counters on the handshake outputs.
module tb_i2c_slave_responder;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic [7:0] tx_next;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       stop_det;
  logic       m_scl;
  logic       m_sda;
  wire        scl_w;
  wire        sda_w;

  int checks = 0;
  int errors = 0;
  int rx_valid_cnt = 0;
  int tx_load_cnt = 0;
  int stop_cnt = 0;
  int drive_cnt = 0;

  pullup pu_scl (scl_w);
  pullup pu_sda (sda_w);
  assign scl_w = m_scl ? 1'bz : 1'b0;
  assign sda_w = m_sda ? 1'bz : 1'b0;

  i2c_slave_responder #(.SLAVE_ADDR(7'b1010101), .SYNC_STAGES(2)) dut (
    .i2c_clock_in (clk),
    .i2c_reset_in (rst),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .stop_det     (stop_det),
    .i2c_scl_inout(scl_w),
    .i2c_sda_inout(sda_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse counters; DUT drive is counted whenever the master releases SDA.
  initial forever begin
    @(negedge clk);
    if (rx_valid) rx_valid_cnt++;
    if (stop_det) stop_cnt++;
    if (m_sda && sda_w === 1'b0) drive_cnt++;
  end

  // Supplies the next read byte after each tx_load has been taken.
  initial forever begin
    @(negedge clk);
    if (tx_load) begin
      tx_load_cnt++;
      @(posedge clk);
      #1 tx_data = tx_next;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    rx_valid_cnt = 0;
    tx_load_cnt  = 0;
    stop_cnt     = 0;
    drive_cnt    = 0;
  endtask

  task automatic m_start();
    m_sda = 1'b1; tick(4);
    m_scl = 1'b1; tick(8);
    m_sda = 1'b0; tick(8);
    m_scl = 1'b0; tick(4);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; tick(4);
    m_scl = 1'b1; tick(8);
    m_sda = 1'b1; tick(8);
  endtask

  // One clock: present b while SCL low, sample the bus mid SCL-high.
  task automatic m_bit(input logic b, output logic s);
    m_sda = b;    tick(4);
    m_scl = 1'b1; tick(4);
    s = sda_w;    tick(4);
    m_scl = 1'b0; tick(4);
  endtask

  task automatic m_byte_w(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_byte_r(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
    m_bit(nack, s);
  endtask

  logic       ack;
  logic       s;
  logic [7:0] rd;

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    tx_data = 8'h00; tx_next = 8'h00;
    tick(5);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_sda", sda_w, 1'b1);
    rst = 1'b0;
    tick(5);
    chk("rst_pulses", {29'd0, rx_valid, tx_load, stop_det}, 32'd0);

    // Write 0xD3 to our address.
    clr_cnt();
    m_start();
    m_byte_w(8'hAA, ack);
    chk("wr_addr_ack", ack, 1'b0);
    chk("wr_busy_mid", busy, 1'b1);
    m_byte_w(8'hD3, ack);
    chk("wr_data_ack", ack, 1'b0);
    chk("wr_busy_pre_stop", busy, 1'b1);
    m_stop();
    chk("wr_rx_data", rx_data, 8'hD3);
    chk("wr_rx_valid_cnt", rx_valid_cnt, 1);
    chk("wr_busy_post", busy, 1'b0);
    chk("wr_stop_cnt", stop_cnt, 1);

    // Foreign address: never driven, no byte, STOP still seen.
    clr_cnt();
    m_start();
    m_byte_w(8'hB2, ack);
    chk("nm_addr_ack", ack, 1'b1);
    chk("nm_busy", busy, 1'b0);
    m_byte_w(8'hFF, ack);
    chk("nm_data_ack", ack, 1'b1);
    m_stop();
    chk("nm_drive_cnt", drive_cnt, 0);
    chk("nm_rx_valid_cnt", rx_valid_cnt, 0);
    chk("nm_stop_cnt", stop_cnt, 1);
    chk("nm_rx_data_kept", rx_data, 8'hD3);

    // Single-byte read of 0x99 ended by NACK.
    clr_cnt();
    tx_data = 8'h99; tx_next = 8'h99;
    m_start();
    m_byte_w(8'hAB, ack);
    chk("rd_addr_ack", ack, 1'b0);
    m_byte_r(1'b1, rd);
    chk("rd_byte", rd, 8'h99);
    chk("rd_tx_load_cnt", tx_load_cnt, 1);
    chk("rd_busy_after_nack", busy, 1'b0);
    m_stop();
    chk("rd_stop_cnt", stop_cnt, 1);

    // Two-byte read: ACK then NACK.
    clr_cnt();
    tx_data = 8'hA5; tx_next = 8'h3C;
    m_start();
    m_byte_w(8'hAB, ack);
    chk("rd2_addr_ack", ack, 1'b0);
    m_byte_r(1'b0, rd);
    chk("rd2_byte0", rd, 8'hA5);
    chk("rd2_busy_mid", busy, 1'b1);
    m_byte_r(1'b1, rd);
    chk("rd2_byte1", rd, 8'h3C);
    chk("rd2_tx_load_cnt", tx_load_cnt, 2);
    m_stop();
    chk("rd2_stop_cnt", stop_cnt, 1);

    // Write 0x12, repeated START into a read, no STOP in between.
    clr_cnt();
    tx_data = 8'h5A; tx_next = 8'h5A;
    m_start();
    m_byte_w(8'hAA, ack);
    chk("rs_wr_addr_ack", ack, 1'b0);
    m_byte_w(8'h12, ack);
    chk("rs_wr_data_ack", ack, 1'b0);
    m_start();
    chk("rs_no_stop", stop_cnt, 0);
    chk("rs_rx_data", rx_data, 8'h12);
    m_byte_w(8'hAB, ack);
    chk("rs_rd_addr_ack", ack, 1'b0);
    m_byte_r(1'b1, rd);
    chk("rs_rd_byte", rd, 8'h5A);
    m_stop();
    chk("rs_rx_valid_cnt", rx_valid_cnt, 1);
    chk("rs_stop_cnt", stop_cnt, 1);

    // Reset while the target drives bit 4 (0) of 0xA5.
    clr_cnt();
    tx_data = 8'hA5; tx_next = 8'hA5;
    m_start();
    m_byte_w(8'hAB, ack);
    chk("rr_addr_ack", ack, 1'b0);
    m_bit(1'b1, s); chk("rr_bit7", s, 1'b1);
    m_bit(1'b1, s); chk("rr_bit6", s, 1'b0);
    m_bit(1'b1, s); chk("rr_bit5", s, 1'b1);
    m_sda = 1'b1; tick(4);
    chk("rr_bit4_low", sda_w, 1'b0);
    rst = 1'b1;
    #1;
    chk("rr_sda_released", sda_w, 1'b1);
    chk("rr_busy", busy, 1'b0);
    chk("rr_rx_data", rx_data, 8'h00);
    tick(5);
    m_scl = 1'b1; m_sda = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(10);
    chk("rr_no_rx_valid", rx_valid_cnt, 0);

    clr_cnt();
    m_start();
    m_byte_w(8'hAA, ack);
    chk("rr_wr_addr_ack", ack, 1'b0);
    m_byte_w(8'h7E, ack);
    chk("rr_wr_data_ack", ack, 1'b0);
    m_stop();
    chk("rr_wr_rx_data", rx_data, 8'h7E);
    chk("rr_wr_rx_valid_cnt", rx_valid_cnt, 1);
    chk("rr_wr_stop_cnt", stop_cnt, 1);
    chk("rr_wr_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
Single-address I2C target that sits directly downstream of i2c_master_controller on the shared i2c_sda_inout/i2c_scl_inout bus. It serves as the on-chip bus partner and system-level verification target. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches the 7-bit address. It ACKs and captures written bytes, and serves read bytes from a local transmit port. Multi-byte transfers and repeated START are supported.

Parameters:
SLAVE_ADDR, 7'b1010101, 7-bit address this target responds to
SYNC_STAGES, 2, synchronizer flops on SCL and SDA (minimum 2)

Ports:
i2c_clock_in  input  1  system clock; all logic on rising edge
i2c_reset_in  input  1  asynchronous, active-high reset
tx_data  input  8  byte returned on reads; sampled when tx_load pulses
tx_load  output  1  one-cycle pulse; tx_data captured this cycle
rx_data  output  8  last byte written by master
rx_valid  output  1  one-cycle pulse; rx_data updated this cycle
busy  output  1  high from matching-address ACK until STOP, NACK-end or address mismatch
stop_det  output  1  one-cycle pulse on every STOP on the bus, addressed or not
i2c_scl_inout  inout  1  serial clock; input only, never driven (no clock stretching)
i2c_sda_inout  inout  1  serial data; open-drain, drives 1'b0 or 1'bz, never 1'b1

Behaviour:
- Reset (asynchronous, active-high): state IDLE. SDA released (z) immediately. Outputs tx_load=0, rx_valid=0, busy=0, stop_det=0, rx_data=8'h00. Shift register and bit counter cleared.
- Input conditioning: SCL and SDA each pass through SYNC_STAGES flops plus one history flop.
- Edge events: scl_rise/scl_fall are synced transitions. START = SDA 1->0 while synced SCL=1. STOP = SDA 0->1 while synced SCL=1.
- Pad-to-event latency is SYNC_STAGES+1 cycles. The bus SCL high/low phases must each be ≥ SYNC_STAGES+2 system clocks.
- Data bits are sampled at scl_rise. This block changes SDA only at scl_fall.
- START in any state (including a repeated START): go to ADDR, clear the bit counter, release SDA.
- STOP in any state: go to IDLE, release SDA, pulse stop_det, clear busy.
- If START and STOP are flagged in the same cycle, STOP wins.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W). At the 8th scl_rise, compare to SLAVE_ADDR.
    - Match: go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP; SDA is never driven.
  - ADDR_ACK: at the next scl_fall, drive SDA low and set busy. At the following scl_fall, release SDA if R/W=0 and go to WRITE. If R/W=1, take the READ path below.
  - ADDR_ACK read path: pulse tx_load one cycle before the releasing scl_fall and capture tx_data. At that scl_fall, drive bit7 (low -> 0, high -> z) and go to READ.
  - WRITE: shift 8 bits. At the 8th scl_rise, update rx_data, pulse rx_valid for one cycle, and go to DATA_ACK.
  - DATA_ACK: drive low at the next scl_fall and release at the following scl_fall, then return to WRITE. Every written byte is ACKed.
  - READ: at each subsequent scl_fall, drive the next bit, bit7 first. After bit0, release SDA at the next scl_fall and go to MACK.
  - MACK: sample SDA at scl_rise.
    - 0 (master ACK): pulse tx_load, reload, drive the new bit7 at the next scl_fall, and return to READ.
    - 1 (master NACK): clear busy and go to WAIT_STOP.
  - WAIT_STOP: SDA released; leave only on STOP (-> IDLE) or START (-> ADDR).
- No outputs are X after reset. The bit counter is 3 bits and wraps at the byte boundary.
- Reset mid-transfer: the bus is released asynchronously and any partial byte is discarded. No rx_valid is issued.

Test Plan:
- Write 0x55/W, data 8'hD3, STOP -> ACK low during both 9th clocks; rx_data=8'hD3; rx_valid one pulse; busy high until STOP; stop_det one pulse.
- Address 7'b1011001/W -> no ACK (SDA z throughout); no rx_valid; busy stays 0; stop_det still pulses at STOP.
- Read 0x55/R with tx_data=8'h99, master NACK, STOP -> tx_load one pulse; SDA bits 1,0,0,1,1,0,0,1 as z,0,0,z,z,0,0,z; state ends in WAIT_STOP, then IDLE.
- Two-byte read: tx_data 8'hA5, then 8'h3C after the first tx_load, master ACK then NACK -> two tx_load pulses; bytes A5, 3C on the bus.
- Write 0x55 data 8'h12, then repeated START with 0x55/R -> rx_data=8'h12; new address phase ACKed; read path entered without an intervening STOP.
- Assert i2c_reset_in while bit 4 of a read byte drives SDA low -> SDA is z in the same cycle; outputs return to reset values; the next full write of 8'h7E completes normally.
